alu4: RTL and testbench

//  Small two-operand integer ALU: add, subtract, bitwise AND, bitwise OR on

---
 rtl/alu4.sv | 96 +++++++++
 tb/tb_alu4.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu4.sv
// rtl/alu4.sv - two-operand ALU (add/sub/and/or) with combinational and registered results
// Optional flag outputs carry_q/zero_q are built only when ALU_FLAGS_EN is defined.

module alu4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic             carry_q,
    output logic             zero_q
`endif
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] diff_w;
    logic [WIDTH-1:0] y_d;
    logic             out_valid_q;

    assign sum_w  = a + b;
    assign diff_w = a - b;

    // Full case with an add default so an unknown opcode never infers a latch.
    always_comb begin
        y = sum_w;
        unique case (op)
            OP_ADD:  y = sum_w;
            OP_SUB:  y = diff_w;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = sum_w;
        endcase
    end

    assign y_d = in_valid ? y : y_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= in_valid;
        end
    end

    assign out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
    logic carry_d;
    logic zero_d;
    logic carry_q_r;
    logic zero_q_r;

    // A wrapped sum is smaller than either addend; borrow is simply a < b.
    always_comb begin
        carry_d = carry_q_r;
        zero_d  = zero_q_r;
        if (in_valid) begin
            zero_d = (y == '0);
            case (op)
                OP_ADD:  carry_d = (sum_w < a);
                OP_SUB:  carry_d = (a < b);
                default: carry_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q_r <= 1'b0;
            zero_q_r  <= 1'b0;
        end else begin
            carry_q_r <= carry_d;
            zero_q_r  <= zero_d;
        end
    end

    assign carry_q = carry_q_r;
    assign zero_q  = zero_q_r;
`endif

endmodule

// File: tb/tb_alu4.sv
// tb/tb_alu4.sv - directed and randomized self-checking bench for alu4
// Flag checks are compiled in only when ALU_FLAGS_EN is defined.

module tb_alu4;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         in_valid;
    logic [W-1:0] y;
    logic [W-1:0] y_q;
    logic         out_valid;
`ifdef ALU_FLAGS_EN
    logic         carry_q;
    logic         zero_q;
`endif

    int total;
    int bad;

    alu4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .op        (op),
        .in_valid  (in_valid),
        .y         (y),
        .y_q       (y_q),
        .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
        ,
        .carry_q   (carry_q),
        .zero_q    (zero_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_y(int av, int bv, int opv);
        case (opv)
            0:       return (av + bv) % M;
            1:       return (av - bv + M) % M;
            2:       return av & bv;
            default: return av | bv;
        endcase
    endfunction

    function automatic int ref_carry(int av, int bv, int opv);
        case (opv)
            0:       return (av + bv >= M) ? 1 : 0;
            1:       return (av < bv) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int av, input int bv, input int opv, input logic v);
        a        = W'(av);
        b        = W'(bv);
        op       = 2'(opv);
        in_valid = v;
    endtask

    initial begin
        int exp_yq;
        int exp_ov;
        int exp_c;
        int exp_z;
        int ra;
        int rb;
        int rop;
        logic rv;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(3, 5, 0, 1'b1);
        #2;
        check("reset_y_q", 32'(y_q), 0);
        check("reset_out_valid", 32'(out_valid), 0);
`ifdef ALU_FLAGS_EN
        check("reset_carry", 32'(carry_q), 0);
        check("reset_zero", 32'(zero_q), 0);
`endif
        check("y_during_reset", 32'(y), 8);
        @(posedge clk); #1;
        check("reset_held_y_q", 32'(y_q), 0);
        @(negedge clk);
        rst = 1'b0;

        // combinational results, no clock edge between drive and check
        drive(3, 5, 0, 1'b0); #1; check("comb_add_3_5", 32'(y), 8);
        drive(3, 5, 1, 1'b0); #1; check("comb_sub_3_5", 32'(y), 14);
        drive(3, 5, 2, 1'b0); #1; check("comb_and_3_5", 32'(y), 1);
        drive(3, 5, 3, 1'b0); #1; check("comb_or_3_5", 32'(y), 7);

        @(negedge clk);
        drive(15, 1, 0, 1'b1); #1;
        check("add_wrap_y", 32'(y), 0);
        @(posedge clk); #1;
        check("add_wrap_y_q", 32'(y_q), 0);
        check("add_wrap_valid", 32'(out_valid), 1);
`ifdef ALU_FLAGS_EN
        check("add_wrap_carry", 32'(carry_q), 1);
        check("add_wrap_zero", 32'(zero_q), 1);
`endif

        @(negedge clk);
        drive(0, 1, 1, 1'b1); #1;
        check("sub_borrow_y", 32'(y), 15);
        @(posedge clk); #1;
        check("sub_borrow_y_q", 32'(y_q), 15);
`ifdef ALU_FLAGS_EN
        check("sub_borrow_carry", 32'(carry_q), 1);
        check("sub_borrow_zero", 32'(zero_q), 0);
`endif

        @(negedge clk);
        drive(5, 5, 1, 1'b1); #1;
        check("sub_equal_y", 32'(y), 0);
        @(posedge clk); #1;
        check("sub_equal_y_q", 32'(y_q), 0);
`ifdef ALU_FLAGS_EN
        check("sub_equal_carry", 32'(carry_q), 0);
        check("sub_equal_zero", 32'(zero_q), 1);
`endif

        @(negedge clk);
        drive(6, 3, 3, 1'b1);
        @(posedge clk); #1;
        check("or_y_q", 32'(y_q), 7);
        check("or_valid", 32'(out_valid), 1);
        @(negedge clk);
        drive(9, 9, 0, 1'b0);
        @(posedge clk); #1;
        check("hold_y_q", 32'(y_q), 7);
        check("hold_valid", 32'(out_valid), 0);

        // async reset between edges discards the in-flight capture
        @(negedge clk);
        drive(6, 3, 3, 1'b1);
        @(posedge clk); #1;
        check("pre_reset_y_q", 32'(y_q), 7);
        #2;
        drive(9, 2, 0, 1'b1);
        rst = 1'b1; #1;
        check("async_reset_y_q", 32'(y_q), 0);
        check("async_reset_valid", 32'(out_valid), 0);
        check("y_tracks_in_reset", 32'(y), 11);
        @(posedge clk); #1;
        check("reset_discard_y_q", 32'(y_q), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(9, 2, 0, 1'b1);
        @(posedge clk); #1;
        check("first_capture_y_q", 32'(y_q), 11);
        check("first_capture_valid", 32'(out_valid), 1);

        // exhaustive combinational sweep
        for (int i = 0; i < M * M * 4; i++) begin
            drive(i % M, (i / M) % M, i / (M * M), 1'b0); #1;
            check("sweep_y", 32'(y), 32'(ref_y(i % M, (i / M) % M, i / (M * M))));
        end

        // randomized back-to-back traffic against the reference model
        @(negedge clk);
        drive(0, 0, 0, 1'b0);
        @(posedge clk); #1;
        exp_yq = int'(y_q);
        exp_yq = 11;
        exp_ov = 0;
`ifdef ALU_FLAGS_EN
        exp_c = ref_carry(9, 2, 0);
        exp_z = 0;
`else
        exp_c = 0;
        exp_z = 0;
`endif
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            ra  = int'($urandom_range(M - 1, 0));
            rb  = int'($urandom_range(M - 1, 0));
            rop = int'($urandom_range(3, 0));
            rv  = 1'($urandom_range(1, 0));
            drive(ra, rb, rop, rv); #1;
            check("rand_y", 32'(y), 32'(ref_y(ra, rb, rop)));
            if (rv) begin
                exp_yq = ref_y(ra, rb, rop);
                exp_c  = ref_carry(ra, rb, rop);
                exp_z  = (exp_yq == 0) ? 1 : 0;
            end
            exp_ov = rv ? 1 : 0;
            @(posedge clk); #1;
            check("rand_y_q", 32'(y_q), 32'(exp_yq));
            check("rand_valid", 32'(out_valid), 32'(exp_ov));
`ifdef ALU_FLAGS_EN
            check("rand_carry", 32'(carry_q), 32'(exp_c));
            check("rand_zero", 32'(zero_q), 32'(exp_z));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
